// File: rtl/butterfly_pkg.sv
// Shared flit encoding for the butterfly switch fabric: flit layout, type codes
// and the ejector FSM state type.
package butterfly_pkg;

   localparam int FLIT_DATA_W = 16;
   localparam int FLIT_W      = FLIT_DATA_W + 2;

   typedef logic [1:0] ftype_t;

   localparam ftype_t FT_HDR  = 2'b11;
   localparam ftype_t FT_PLD  = 2'b10;
   localparam ftype_t FT_NULL = 2'b00;
   localparam ftype_t FT_RSV  = 2'b01;

   typedef struct packed {
      ftype_t                   ftype;
      logic [FLIT_DATA_W-1:0]   data;
   } flit_t;

   localparam int ROUTE_HI = 15;
   localparam int ROUTE_LO = 14;

   function automatic logic [1:0] route_of(input logic [FLIT_DATA_W-1:0] hdr_data);
      return hdr_data[ROUTE_HI:ROUTE_LO];
   endfunction

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HOLD = 2'd1,
      ST_DROP = 2'd2
   } ej_state_t;

endpackage

// File: rtl/flit_fifo.sv
// First-word fall-through FIFO holding {hdr, last, err, data} entries for the
// flit ejector; head is forced to zero while empty.
module flit_fifo #(
   parameter int DEPTH = 8,
   parameter int W     = 19
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic [W-1:0]               push_data,
   input  logic                       pop,
   output logic                       out_valid,
   output logic [W-1:0]               out_data,
   output logic [$clog2(DEPTH):0]     level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [LW-1:0] level_q, level_d;
   logic          do_push, do_pop, empty, full;

   always_comb begin
      empty    = (level_q == '0);
      full     = (level_q == FULL_LVL);
      do_pop   = pop && !empty;
      // a full FIFO can still take a word when the head leaves in the same cycle
      do_push  = push && (!full || do_pop);
      wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
      level_d  = level_q;
      if (do_push && !do_pop)
         level_d = level_q + 1'b1;
      else if (!do_push && do_pop)
         level_d = level_q - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push)
         mem_q[wr_ptr_q] <= push_data;
   end

   assign out_valid = !empty;
   assign out_data  = empty ? '0 : mem_q[rd_ptr_q];
   assign level     = level_q;

endmodule

// File: rtl/flit_ejector.sv
// Ejection stage for one switch output lane: parses flits into packets, buffers
// them and truncates packets when the buffer would overflow.
//
//  state | meaning
//  IDLE  | nothing held, waiting for a header
//  HOLD  | one HDR/PLD word held until its successor decides its last bit
//  DROP  | packet truncated, discarding flits until NULL or next HDR
module flit_ejector
   import butterfly_pkg::*;
#(
   parameter int DEPTH  = 8,
   parameter int DATA_W = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [DATA_W+1:0]        in_flit,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [DATA_W-1:0]        out_data,
   output logic                     out_hdr,
   output logic                     out_last,
   output logic                     out_err,
   output logic [$clog2(DEPTH):0]   fifo_level,
   output logic                     ovf_err,
   output logic                     proto_err
);

   localparam int LW = $clog2(DEPTH) + 1;
   localparam int EW = DATA_W + 3;
   localparam logic [LW-1:0] ROOM_LVL = LW'(DEPTH - 2);

   ej_state_t          state_q, state_d;
   logic [DATA_W-1:0]  hold_data_q, hold_data_d;
   logic               hold_hdr_q, hold_hdr_d;
   logic               ovf_q, ovf_d;
   logic               proto_q, proto_d;

   ftype_t             ftype;
   logic [DATA_W-1:0]  fdata;
   logic               room;
   logic               push, push_last, push_err, load_hold, set_ovf, set_proto;
   logic               fifo_valid, pop;
   logic [EW-1:0]      fifo_head;
   logic [LW-1:0]      level;

   assign ftype = in_flit[DATA_W+1:DATA_W];
   assign fdata = in_flit[DATA_W-1:0];
   assign room  = (level <= ROOM_LVL);
   assign pop   = fifo_valid && out_ready;

   always_ff @(posedge clk) begin
      if (rst)
         state_q <= ST_IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: if (ftype == FT_HDR) state_d = ST_HOLD;
         ST_HOLD: begin
            if (ftype == FT_PLD)
               state_d = room ? ST_HOLD : ST_DROP;
            else if (ftype != FT_HDR)
               state_d = ST_IDLE;
         end
         ST_DROP: begin
            if (ftype == FT_NULL)
               state_d = ST_IDLE;
            else if (ftype == FT_HDR)
               state_d = ST_HOLD;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      push      = 1'b0;
      push_last = 1'b0;
      push_err  = 1'b0;
      load_hold = 1'b0;
      set_ovf   = 1'b0;
      set_proto = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (ftype == FT_HDR)
               load_hold = 1'b1;
            else if (ftype != FT_NULL)
               set_proto = 1'b1;
         end
         ST_HOLD: begin
            push = 1'b1;
            unique case (ftype)
               FT_PLD: begin
                  if (room) begin
                     load_hold = 1'b1;
                  end else begin
                     push_last = 1'b1;
                     push_err  = 1'b1;
                     set_ovf   = 1'b1;
                  end
               end
               FT_HDR: begin
                  push_last = 1'b1;
                  load_hold = 1'b1;
               end
               FT_RSV: begin
                  push_last = 1'b1;
                  push_err  = 1'b1;
                  set_proto = 1'b1;
               end
               default: push_last = 1'b1;
            endcase
         end
         ST_DROP: begin
            if (ftype == FT_HDR)
               load_hold = 1'b1;
            else if (ftype == FT_RSV)
               set_proto = 1'b1;
         end
         default: ;
      endcase
   end

   always_comb begin
      hold_data_d = load_hold ? fdata : hold_data_q;
      hold_hdr_d  = load_hold ? (ftype == FT_HDR) : hold_hdr_q;
      ovf_d       = ovf_q   | set_ovf;
      proto_d     = proto_q | set_proto;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hold_data_q <= '0;
         hold_hdr_q  <= 1'b0;
         ovf_q       <= 1'b0;
         proto_q     <= 1'b0;
      end else begin
         hold_data_q <= hold_data_d;
         hold_hdr_q  <= hold_hdr_d;
         ovf_q       <= ovf_d;
         proto_q     <= proto_d;
      end
   end

   flit_fifo #(
      .DEPTH (DEPTH),
      .W     (EW)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data ({hold_hdr_q, push_last, push_err, hold_data_q}),
      .pop       (pop),
      .out_valid (fifo_valid),
      .out_data  (fifo_head),
      .level     (level)
   );

   assign out_valid  = fifo_valid;
   assign out_hdr    = fifo_head[EW-1];
   assign out_last   = fifo_head[EW-2];
   assign out_err    = fifo_head[EW-3];
   assign out_data   = fifo_head[DATA_W-1:0];
   assign fifo_level = level;
   assign ovf_err    = ovf_q;
   assign proto_err  = proto_q;

endmodule
